// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the uart_tx request scheduler.
package uart_pkg;
    localparam int FULL_DATA_SIZE = 40;
    localparam int BYTE_SIZE      = 8;
    localparam int MAX_LEN        = 3;
    // LSB positions of the length and opt fields inside one message word
    localparam int LEN_OFS        = FULL_DATA_SIZE - 2 * BYTE_SIZE;
    localparam int OPT_OFS        = FULL_DATA_SIZE - BYTE_SIZE;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin first-set-bit search starting at a pointer, with wrap.
// The pointer moves to one past the winner on each advance strobe.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any
);
    logic [IW-1:0] ptr;

    always_comb begin
        int j;
        j     = 0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            ptr <= '0;
        else if (advance && any)
            ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
    end
endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between NUM_REQ message sources: picks a source round-robin,
// launches its word, then waits for the frame to finish before the next grant.
module uart_tx_sched #(
    parameter  int NUM_REQ         = 4,
    parameter  int FULL_DATA_SIZE  = uart_pkg::FULL_DATA_SIZE,
    parameter  int BYTE_SIZE       = uart_pkg::BYTE_SIZE,
    parameter  int MAX_LEN         = uart_pkg::MAX_LEN,
    parameter  int IN_VALID_CYCLES = 2,
    parameter  int BUSY_TIMEOUT    = 8,
    localparam int IW              = $clog2(NUM_REQ)
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*FULL_DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                req_err,
    output logic [FULL_DATA_SIZE-1:0]         full_data,
    output logic                              in_valid,
    input  logic                              tx_busy,
    output logic [IW-1:0]                     grant_id,
    output logic                              timeout
);
    import uart_pkg::*;

    localparam int LEN_MSB = FULL_DATA_SIZE - BYTE_SIZE - 1;
    localparam int CNT_MAX = (IN_VALID_CYCLES > BUSY_TIMEOUT) ? IN_VALID_CYCLES : BUSY_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t                    state, state_nx;
    logic [CW-1:0]             cnt, cnt_nx;
    logic [NUM_REQ-1:0]        grant;
    logic [IW-1:0]             idx;
    logic                      any;
    logic                      advance;
    logic [FULL_DATA_SIZE-1:0] word;
    logic                      len_bad;

    assign word    = req_data[idx*FULL_DATA_SIZE +: FULL_DATA_SIZE];
    assign len_bad = word[LEN_MSB -: BYTE_SIZE] > BYTE_SIZE'(MAX_LEN);
    // Rejected words still consume the source's turn, so the pointer advances on both outcomes.
    assign advance = (state == IDLE) && RST && any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (CLK),
        .rst     (RST),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant),
        .idx     (idx),
        .any     (any)
    );

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        req_ready = '0;
        req_err   = '0;
        in_valid  = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (advance) begin
                    if (len_bad) begin
                        req_err = grant;
                    end else begin
                        req_ready = grant;
                        state_nx  = LAUNCH;
                        cnt_nx    = '0;
                    end
                end
            end
            LAUNCH: begin
                in_valid = 1'b1;
                if (cnt == CW'(IN_VALID_CYCLES - 1)) begin
                    state_nx = WAIT_BUSY;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WAIT_BUSY: begin
                // A late busy on the final counted cycle still wins over the timeout.
                if (tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (cnt == CW'(BUSY_TIMEOUT)) begin
                    timeout  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            full_data <= '0;
            grant_id  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (advance) begin
                grant_id <= idx;
                if (!len_bad)
                    full_data <= word;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a time-since-grant scheduler model checked every cycle,
// a simple uart_tx busy model, and directed scenarios with literal expectations.
module tb_uart_tx_sched;
    localparam int N    = 4;
    localparam int FDS  = 40;
    localparam int IVC  = 2;
    localparam int BT   = 8;
    localparam int MAXL = 3;

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*FDS-1:0] req_data = '0;
    logic           tx_busy = 1'b0;
    logic [N-1:0]   req_ready, req_err;
    logic [FDS-1:0] full_data;
    logic           in_valid, timeout;
    logic [1:0]     grant_id;

    uart_tx_sched #(.NUM_REQ(N)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .req_err   (req_err),
        .full_data (full_data),
        .in_valid  (in_valid),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .timeout   (timeout)
    );

    initial forever #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0, cyc = 0;
    // scheduler model: free flag, cycles since accept, busy-seen flag
    bit             m_free = 1'b1, m_saw = 1'b0;
    int             m_ts = 0, m_ptr = 0, m_gid = 0;
    logic [FDS-1:0] m_full = '0;
    int             glog[$], elog[$];
    int             iv_cnt = 0, iv_fall = -1, to_cyc = -1;
    bit             prev_iv = 1'b0;
    logic [N-1:0]   drop_mask = '0;
    bit             start_pend = 1'b0, uart_en = 1'b1;
    int             busy_left = 0, busy_len = 30;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int gl(input int i);
        return (i >= 0 && i < glog.size()) ? glog[i] : -1;
    endfunction

    function automatic int el(input int i);
        return (i >= 0 && i < elog.size()) ? elog[i] : -1;
    endfunction

    // compare process: outputs sampled mid-cycle against the model
    initial begin : cmp
        logic [N-1:0]   e_rdy, e_err;
        logic [FDS-1:0] w;
        bit             e_iv, e_to;
        int             g;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_req_err", req_err, 0);
                m_free = 1'b1; m_ptr = 0; m_full = '0; m_gid = 0;
                busy_left = 0; start_pend = 1'b0; prev_iv = 1'b0;
            end else begin
                chk("full_data", full_data, m_full);
                chk("grant_id", grant_id, m_gid);
                e_rdy = '0; e_err = '0; e_iv = 1'b0; e_to = 1'b0;
                if (m_free) begin
                    g = -1;
                    for (int k = 0; k < N; k++)
                        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                    if (g >= 0) begin
                        w     = req_data[g*FDS +: FDS];
                        m_ptr = (g + 1) % N;
                        m_gid = g;
                        if (w[31:24] > MAXL) begin
                            e_err[g] = 1'b1;
                        end else begin
                            e_rdy[g] = 1'b1;
                            m_full = w; m_free = 1'b0; m_ts = 0; m_saw = 1'b0;
                        end
                    end
                end else begin
                    m_ts++;
                    e_iv = (m_ts <= IVC);
                    if (m_ts > IVC) begin
                        if (!m_saw) begin
                            if (tx_busy) m_saw = 1'b1;
                            else if (m_ts - IVC - 1 == BT) begin e_to = 1'b1; m_free = 1'b1; end
                        end else if (!tx_busy) begin
                            m_free = 1'b1;
                        end
                    end
                end
                chk("req_ready", req_ready, e_rdy);
                chk("req_err", req_err, e_err);
                chk("in_valid", in_valid, e_iv);
                chk("timeout", timeout, e_to);
                for (int k = 0; k < N; k++) begin
                    if (req_ready[k]) glog.push_back(k);
                    if (req_err[k]) elog.push_back(k);
                end
                drop_mask = drop_mask | req_ready | req_err;
                if (in_valid) iv_cnt++;
                if (!in_valid && prev_iv) iv_fall = cyc;
                if (timeout) to_cyc = cyc;
                if (in_valid && !prev_iv && uart_en) start_pend = 1'b1;
                prev_iv = in_valid;
            end
        end
    end

    // uart_tx stand-in: busy for busy_len cycles starting the cycle after in_valid rises
    initial forever begin
        @(posedge CLK); #1;
        if (start_pend) begin busy_left = busy_len; start_pend = 1'b0; end
        if (busy_left > 0) begin tx_busy = 1'b1; busy_left--; end
        else tx_busy = 1'b0;
    end

    task automatic tick();
        @(posedge CLK); #1;
        req_valid = req_valid & ~drop_mask;
        drop_mask = '0;
    endtask

    task automatic set_word(input int i, input logic [FDS-1:0] w);
        req_data[i*FDS +: FDS] = w;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!(m_free && req_valid == '0) && k < 500) begin tick(); k++; end
        n_chk++;
        if (k >= 500) begin
            n_fail++;
            $display("FAIL %s: got still busy after 500 cycles expected idle", name);
        end
    endtask

    task automatic wait_grants(input int n, input string name);
        int k = 0;
        while (glog.size() < n && k < 500) begin tick(); k++; end
        n_chk++;
        if (k >= 500) begin
            n_fail++;
            $display("FAIL %s: got %0d grants expected %0d", name, glog.size(), n);
        end
    endtask

    initial begin : stim
        int base, iv0;
        repeat (3) tick();
        RST = 1'b1;
        @(negedge CLK);
        chk("reset_full_data", full_data, 0);
        chk("reset_in_valid", in_valid, 0);
        chk("reset_grant_id", grant_id, 0);
        chk("reset_timeout", timeout, 0);

        // single request
        tick();
        set_word(0, 40'h00_03_aa_bb_47);
        req_valid = 4'b0001;
        wait_idle("single");
        chk("single_grants", glog.size(), 1);
        chk("single_src", gl(0), 0);
        chk("single_iv_cycles", iv_cnt, 2);
        chk("single_full", full_data, 40'h00_03_aa_bb_47);
        chk("single_gid", grant_id, 0);

        // illegal length from source 1
        set_word(1, 40'h00_04_11_22_33);
        iv0 = iv_cnt;
        req_valid = 4'b0010;
        wait_idle("illegal");
        chk("illegal_err_src", el(0), 1);
        chk("illegal_no_iv", iv_cnt, iv0);
        chk("illegal_no_grant", glog.size(), 1);
        chk("illegal_full_kept", full_data, 40'h00_03_aa_bb_47);

        // pointer now 2: source 2 must beat source 1
        set_word(1, 40'h01_01_00_00_5a);
        set_word(2, 40'h00_02_00_12_34);
        req_valid = 4'b0110;
        wait_idle("ptr2");
        chk("ptr2_first", gl(1), 2);
        chk("ptr2_second", gl(2), 1);

        // zero length from source 3
        set_word(3, 40'h00_00_aa_bb_47);
        req_valid = 4'b1000;
        wait_idle("zero_len");
        chk("zero_len_src", gl(3), 3);
        chk("zero_len_full", full_data, 40'h00_00_aa_bb_47);

        // all four pending, pointer 0
        base = glog.size();
        set_word(0, 40'h00_01_00_00_c3);
        req_valid = 4'b1111;
        wait_idle("four_way");
        for (int k = 0; k < N; k++) chk("four_way_order", gl(base + k), k);

        // 0 and 2 contend, 0 re-requests during 2's frame
        base = glog.size();
        req_valid = 4'b0101;
        wait_grants(base + 2, "contend");
        req_valid[0] = 1'b1;
        wait_idle("contend");
        chk("contend_1st", gl(base), 0);
        chk("contend_2nd", gl(base + 1), 2);
        chk("contend_3rd", gl(base + 2), 0);

        // busy never rises
        uart_en = 1'b0;
        iv_fall = -1; to_cyc = -1;
        req_valid = 4'b0010;
        wait_idle("timeout");
        chk("timeout_gap", to_cyc - iv_fall, 8);
        uart_en = 1'b1;
        req_valid = 4'b0100;
        wait_idle("after_timeout");
        chk("after_timeout_src", gl(glog.size() - 1), 2);

        // reset while in WAIT_DONE with sources 1 and 3 pending
        base = glog.size();
        req_valid = 4'b0100;
        wait_grants(base + 1, "rst_frame");
        repeat (6) tick();
        req_valid = req_valid | 4'b1010;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_in_valid", in_valid, 0);
        chk("rst_mid_full", full_data, 0);
        chk("rst_mid_gid", grant_id, 0);
        chk("rst_mid_timeout", timeout, 0);
        chk("rst_mid_ready", req_ready, 4'b0010);
        wait_idle("post_reset");
        chk("post_reset_1st", gl(base + 1), 1);
        chk("post_reset_2nd", gl(base + 2), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
